alu_writeback: RTL and testbench



---
 rtl/alu_writeback_pkg.sv | 43 ++++
 rtl/alu_writeback_pipe_skid.sv | 60 ++++++
 rtl/alu_writeback.sv | 80 ++++++++
 tb/tb_alu_writeback.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared opcode-level definitions: status flag bit positions, branch
// condition selector encoding and its evaluation against the status word.
package opcodes;

    // Bit positions of the flags inside the ALU Flags bus and the Status register
    localparam int unsigned FLAGS_Z = 0;
    localparam int unsigned FLAGS_N = 1;
    localparam int unsigned FLAGS_C = 2;
    localparam int unsigned FLAGS_V = 3;
    localparam int unsigned FLAGS_W = 4;

    // Branch condition selector used by the decoder
    typedef enum logic [2:0] {
        AL = 3'd0,
        EQ = 3'd1,
        NE = 3'd2,
        CS = 3'd3,
        CC = 3'd4,
        MI = 3'd5,
        PL = 3'd6,
        NV = 3'd7
    } branch_cond_t;

    // Evaluate a branch condition against a status word (V is not consulted)
    function automatic logic eval_cond(input branch_cond_t cond,
                                       input logic [FLAGS_W-1:0] status);
        logic result;
        result = 1'b0;
        case (cond)
            AL:      result = 1'b1;
            EQ:      result = status[FLAGS_Z];
            NE:      result = ~status[FLAGS_Z];
            CS:      result = status[FLAGS_C];
            CC:      result = ~status[FLAGS_C];
            MI:      result = status[FLAGS_N];
            PL:      result = ~status[FLAGS_N];
            NV:      result = 1'b0;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/alu_writeback_pipe_skid.sv
// Two-entry skid buffer with valid/ready handshake. Entry M is the head and
// drives the outputs directly; entry S catches one extra beat while M stalls.
// in_ready depends only on registered state, so it never forms a
// combinational path from out_ready back to the producer.
module pipe_skid #(
    parameter int unsigned PW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_payload
);

    logic [PW-1:0] m_payload;
    logic [PW-1:0] s_payload;
    logic          m_valid;
    logic          s_valid;
    logic          accept;
    logic          pop;

    // Handshake qualifiers for the current cycle
    always_comb begin
        accept = in_valid & ~s_valid;
        pop    = m_valid & out_ready;
    end

    // M/S update; S can only hold data while M does, so draining S always
    // goes through M and ordering is preserved
    always_ff @(posedge clock) begin
        if (reset) begin
            m_payload <= '0;
            s_payload <= '0;
            m_valid   <= 1'b0;
            s_valid   <= 1'b0;
        end else if (s_valid && pop) begin
            m_payload <= s_payload;
            s_valid   <= 1'b0;
        end else if (accept && (!m_valid || pop)) begin
            m_payload <= in_payload;
            m_valid   <= 1'b1;
        end else if (accept && m_valid && !pop) begin
            s_payload <= in_payload;
            s_valid   <= 1'b1;
        end else if (pop) begin
            m_valid   <= 1'b0;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        in_ready    = ~s_valid;
        out_valid   = m_valid;
        out_payload = m_payload;
    end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the 16-bit ALU: buffers results for the register
// file write port, owns the architectural status register (Z, N, C, V),
// feeds the stored carry back to the ALU and evaluates branch conditions.
module alu_writeback
    import opcodes::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   Result,
    input  logic [FLAGS_W-1:0] Flags,
    input  logic               InValid,
    output logic               InReady,
    input  logic               WrEn,
    input  logic [AW-1:0]      WrAddr,
    input  logic               FlagsEn,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   OutData,
    output logic [AW-1:0]      OutAddr,
    output logic               OutWrEn,
    output logic [FLAGS_W-1:0] Status,
    output logic               CarryOut,
    input  logic [2:0]         Cond,
    output logic               CondTrue
);

    localparam int unsigned PW = 1 + AW + WIDTH;

    logic [PW-1:0]      in_payload;
    logic [PW-1:0]      out_payload;
    logic               accept;
    logic [FLAGS_W-1:0] status_q;

    // Pack the write-port payload as {wren, addr, data}
    always_comb begin
        in_payload = {WrEn, WrAddr, Result};
    end

    pipe_skid #(
        .PW (PW)
    ) u_skid (
        .clock       (Clock),
        .reset       (Reset),
        .in_valid    (InValid),
        .in_ready    (InReady),
        .in_payload  (in_payload),
        .out_valid   (OutValid),
        .out_ready   (OutReady),
        .out_payload (out_payload)
    );

    // Unpack the head entry onto the register-file write port
    always_comb begin
        OutWrEn = out_payload[PW-1];
        OutAddr = out_payload[WIDTH +: AW];
        OutData = out_payload[WIDTH-1:0];
        accept  = InValid & InReady;
    end

    // Flags commit at acceptance, not at pop, so a dependent ADC/SUC sees the
    // new carry on the next cycle even while the write port is stalled
    always_ff @(posedge Clock) begin
        if (Reset) begin
            status_q <= '0;
        end else if (accept && FlagsEn) begin
            status_q <= Flags;
        end
    end

    // Status export, carry feedback and branch condition evaluation
    always_comb begin
        Status   = status_q;
        CarryOut = status_q[FLAGS_C];
        CondTrue = eval_cond(branch_cond_t'(Cond), status_q);
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios followed by randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_alu_writeback;

    logic        Clock;
    logic        Reset;
    logic [15:0] Result;
    logic [3:0]  Flags;
    logic        InValid;
    logic        InReady;
    logic        WrEn;
    logic [2:0]  WrAddr;
    logic        FlagsEn;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] OutData;
    logic [2:0]  OutAddr;
    logic        OutWrEn;
    logic [3:0]  Status;
    logic        CarryOut;
    logic [2:0]  Cond;
    logic        CondTrue;

    alu_writeback #(
        .WIDTH (16),
        .AW    (3)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Result   (Result),
        .Flags    (Flags),
        .InValid  (InValid),
        .InReady  (InReady),
        .WrEn     (WrEn),
        .WrAddr   (WrAddr),
        .FlagsEn  (FlagsEn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutAddr  (OutAddr),
        .OutWrEn  (OutWrEn),
        .Status   (Status),
        .CarryOut (CarryOut),
        .Cond     (Cond),
        .CondTrue (CondTrue)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  a;
        logic        w;
    } ent_t;

    // Reference model: FIFO of at most two entries plus the status word
    ent_t        q[$];
    ent_t        held;
    logic [3:0]  st;
    logic        last_acc;
    int          checks;
    int          failures;

    function automatic logic cond_ref(input logic [2:0] c, input logic [3:0] s);
        // s = {V, C, N, Z}
        case (c)
            3'd0: return 1'b1;
            3'd1: return s[0];
            3'd2: return !s[0];
            3'd3: return s[2];
            3'd4: return !s[2];
            3'd5: return s[1];
            3'd6: return !s[1];
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check every output against the model, then
    // advance the model across the rising edge
    task automatic step(input logic rst, input logic iv, input logic [15:0] res,
                        input logic [3:0] fl, input logic we, input logic [2:0] wa,
                        input logic fe, input logic ordy, input logic [2:0] cd);
        ent_t head;
        logic exp_valid;
        logic acc;
        logic pop;
        Reset = rst; InValid = iv; Result = res; Flags = fl; WrEn = we;
        WrAddr = wa; FlagsEn = fe; OutReady = ordy; Cond = cd;
        #1;
        exp_valid = (q.size() != 0);
        head = exp_valid ? q[0] : held;
        check("out_valid", 32'(OutValid), 32'(exp_valid));
        check("out_data",  32'(OutData),  32'(head.d));
        check("out_addr",  32'(OutAddr),  32'(head.a));
        check("out_wren",  32'(OutWrEn),  32'(head.w));
        check("in_ready",  32'(InReady),  32'(q.size() < 2));
        check("status",    32'(Status),   32'(st));
        check("carry_out", 32'(CarryOut), 32'(st[2]));
        check("cond_true", 32'(CondTrue), 32'(cond_ref(cd, st)));
        acc = iv && (q.size() < 2);
        pop = ordy && exp_valid;
        if (rst) begin
            q.delete();
            held = '{d: 16'h0, a: 3'h0, w: 1'b0};
            st = 4'h0;
            last_acc = 1'b0;
        end else begin
            if (acc && fe) st = fl;
            if (exp_valid) held = q[0];
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{d: res, a: wa, w: we});
            last_acc = acc;
        end
        @(negedge Clock);
    endtask

    logic        r_iv;
    logic [15:0] r_res;
    logic [3:0]  r_fl;
    logic        r_we;
    logic [2:0]  r_wa;
    logic        r_fe;
    logic        r_rst;

    initial begin
        checks = 0;
        failures = 0;
        held = '{d: 16'h0, a: 3'h0, w: 1'b0};
        st = 4'h0;
        last_acc = 1'b0;
        Reset = 1'b1; InValid = 1'b0; Result = '0; Flags = '0; WrEn = 1'b0;
        WrAddr = '0; FlagsEn = 1'b0; OutReady = 1'b0; Cond = 3'd0;
        @(negedge Clock);
        step(1, 0, 16'h0, 4'h0, 0, 3'd0, 0, 0, 3'd0);

        // Reset then idle: AL true, CS false
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd0);
        check("idle_al", 32'(CondTrue), 32'(1));
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd3);

        // Single accept, visible next cycle, drains one cycle later
        step(0, 1, 16'h1234, 4'h0, 1, 3'd3, 0, 1, 3'd0);
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd0);
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd0);

        // Carry chain with FlagsEn=1 then with FlagsEn=0
        step(0, 1, 16'h0001, 4'b0100, 1, 3'd1, 1, 1, 3'd3);
        step(0, 1, 16'h0002, 4'b0000, 1, 3'd2, 0, 1, 3'd3);
        check("carry_set", 32'(CarryOut), 32'(1));
        step(0, 1, 16'h0003, 4'b0000, 1, 3'd1, 1, 1, 3'd3);
        step(0, 1, 16'h0004, 4'b0100, 1, 3'd1, 0, 1, 3'd3);
        step(0, 1, 16'h0005, 4'b0000, 1, 3'd2, 0, 1, 3'd3);
        check("carry_held", 32'(CarryOut), 32'(0));
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd0);
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd0);

        // Back-pressure: A, B accepted, C held until S drains
        step(0, 1, 16'hAAAA, 4'h0, 1, 3'd4, 0, 0, 3'd0);
        step(0, 1, 16'hBBBB, 4'h0, 0, 3'd5, 0, 0, 3'd0);
        step(0, 1, 16'hCCCC, 4'h0, 1, 3'd6, 0, 0, 3'd0);
        check("bp_stall", 32'(InReady), 32'(0));
        step(0, 1, 16'hCCCC, 4'h0, 1, 3'd6, 0, 1, 3'd0);
        step(0, 1, 16'hCCCC, 4'h0, 1, 3'd6, 0, 1, 3'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd0);

        // Condition mux with Z=1, N=0, C=0
        step(0, 1, 16'h0000, 4'b0001, 0, 3'd0, 1, 1, 3'd0);
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd1);
        check("cond_eq", 32'(CondTrue), 32'(1));
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd2);
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd6);
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd4);
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 1, 3'd7);

        // Reset with both entries full and an accept pending
        step(0, 1, 16'h1111, 4'b1111, 1, 3'd7, 1, 0, 3'd0);
        step(0, 1, 16'h2222, 4'b0110, 1, 3'd6, 1, 0, 3'd0);
        step(1, 1, 16'h3333, 4'b1010, 1, 3'd5, 1, 1, 3'd0);
        step(0, 0, 16'h0, 4'h0, 0, 3'd0, 0, 0, 3'd3);
        check("reset_status", 32'(Status), 32'(0));

        // Randomized traffic; a refused beat is held stable as upstream must
        r_iv = 1'b0; r_res = '0; r_fl = '0; r_we = 1'b0; r_wa = '0; r_fe = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(r_iv && !last_acc)) begin
                r_iv  = ($urandom_range(0, 3) != 0);
                r_res = 16'($urandom);
                r_fl  = 4'($urandom);
                r_we  = 1'($urandom);
                r_wa  = 3'($urandom);
                r_fe  = 1'($urandom);
            end
            r_rst = ($urandom_range(0, 79) == 0);
            step(r_rst, r_iv, r_res, r_fl, r_we, r_wa, r_fe,
                 ($urandom_range(0, 2) != 0), 3'($urandom));
            if (r_rst) r_iv = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
